// File: rtl/avalon_button_led_slave_pkg.sv
// Shared definitions for the button/LED/switch Avalon-MM register block.
//   reg_addr_t      : 2-bit word address of a register
//   ADDR_*          : register map (STATUS, LED, EDGE, MASK)
//   SW_LSB/BTN_LSB  : field offsets inside the STATUS word
//   apply_byteenable: merges write data into an old word, one byte lane at a time
package button_led_pkg;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_STATUS = 2'd0;
  localparam reg_addr_t ADDR_LED    = 2'd1;
  localparam reg_addr_t ADDR_EDGE   = 2'd2;
  localparam reg_addr_t ADDR_MASK   = 2'd3;

  localparam int SW_LSB  = 0;
  localparam int BTN_LSB = 16;

  function automatic logic [31:0] apply_byteenable(input logic [31:0] old_word,
                                                   input logic [31:0] new_word,
                                                   input logic [3:0]  byteenable);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byteenable[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/avalon_button_led_slave_if.sv
// Avalon-MM bus bundle between the Nios II data master and the button/LED slave.
//   avs_address/read/write/writedata/byteenable : master -> slave
//   avs_readdata/avs_irq                         : slave -> master
// Transfer semantics: avs_read and avs_write are single-cycle strobes with no
// waitrequest, so every strobe is accepted on the clock edge that samples it.
// A write takes effect on that edge; a read registers avs_readdata on that edge
// and the value is held until the next read.
interface avalon_button_led_slave_if;
  import button_led_pkg::*;

  reg_addr_t   avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_irq;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_irq
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_irq
  );

endinterface

// File: rtl/avalon_button_led_slave_debouncer.sv
// button_debouncer: one button channel.
//   clk, reset_n : clock, asynchronous active-low reset
//   btn_raw      : raw asynchronous button (active high)
//   btn_db       : debounced level
//   btn_rise     : one-cycle pulse the cycle after btn_db goes 0->1
// The synchronised input must differ from the debounced value for
// DEBOUNCE_CYCLES consecutive cycles before it is accepted; any return to the
// debounced value restarts the count, so bounces shorter than that are dropped.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      db_q      <= 1'b0;
      db_d      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
      db_d      <= db_q;
      if (sync_q != db_q) begin
        if (cnt_q == CNT_MAX) begin
          db_q  <= sync_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign btn_db   = db_q;
  assign btn_rise = db_q & ~db_d;

endmodule

// File: rtl/avalon_button_led_slave.sv
// avalon_button_led_slave: Avalon-MM register block for buttons, switches, LEDs.
//   clk, reset_n : 50 MHz clock, asynchronous active-low reset
//   bus          : Avalon-MM slave modport (address/read/write/data/irq)
//   btn_in       : raw buttons, active high
//   sw_in        : raw switches
//   led_out      : LED drive
// Register map: 0 STATUS (RO), 1 LED (RW, byte-enabled), 2 EDGE (RW1C),
// 3 MASK (RW). Define BTN_IRQ_EN to build the MASK register and avs_irq;
// without it address 3 reads zero and avs_irq is tied low.
module avalon_button_led_slave
  import button_led_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int NUM_SW          = 8,
  parameter int NUM_LED         = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  avalon_button_led_slave_if.slave    bus,
  input  logic [NUM_BTN-1:0]          btn_in,
  input  logic [NUM_SW-1:0]           sw_in,
  output logic [NUM_LED-1:0]          led_out
);

  logic [NUM_SW-1:0]  sw_meta;
  logic [NUM_SW-1:0]  sw_sync;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] edge_q;
  logic [NUM_BTN-1:0] edge_clr;
  logic [NUM_BTN-1:0] edge_next;
  logic [NUM_LED-1:0] led_q;
  logic [31:0]        led_merged;
  logic [31:0]        rd_mux;
  logic [31:0]        readdata_q;
  logic               wr_led;
  logic               wr_edge;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw  (btn_in[i]),
      .btn_db   (btn_db[i]),
      .btn_rise (btn_rise[i])
    );
  end

  assign wr_led  = bus.avs_write && (bus.avs_address == ADDR_LED);
  assign wr_edge = bus.avs_write && (bus.avs_address == ADDR_EDGE) && bus.avs_byteenable[0];

  always_comb begin
    led_merged = apply_byteenable(32'(led_q), bus.avs_writedata, bus.avs_byteenable);
    edge_clr   = '0;
    if (wr_edge) edge_clr = bus.avs_writedata[NUM_BTN-1:0];
    // Rise is ORed in after the clear so a simultaneous new edge is never lost.
    edge_next = (edge_q & ~edge_clr) | btn_rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led_q   <= '0;
      edge_q  <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      edge_q  <= edge_next;
      if (wr_led) led_q <= led_merged[NUM_LED-1:0];
    end
  end

`ifdef BTN_IRQ_EN
  logic [NUM_BTN-1:0] mask_q;
  logic               irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (bus.avs_write && (bus.avs_address == ADDR_MASK) && bus.avs_byteenable[0])
        mask_q <= bus.avs_writedata[NUM_BTN-1:0];
      irq_q <= |(edge_q & mask_q);
    end
  end

  assign bus.avs_irq = irq_q;
`else
  assign bus.avs_irq = 1'b0;
`endif

  // Read mux samples current register contents, so a read in the same cycle
  // as a write returns the pre-write value.
  always_comb begin
    rd_mux = '0;
    case (bus.avs_address)
      ADDR_STATUS: begin
        rd_mux[SW_LSB  +: NUM_SW]  = sw_sync;
        rd_mux[BTN_LSB +: NUM_BTN] = btn_db;
      end
      ADDR_LED:  rd_mux[NUM_LED-1:0] = led_q;
      ADDR_EDGE: rd_mux[NUM_BTN-1:0] = edge_q;
`ifdef BTN_IRQ_EN
      ADDR_MASK: rd_mux[NUM_BTN-1:0] = mask_q;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          readdata_q <= '0;
    else if (bus.avs_read) readdata_q <= rd_mux;
  end

  assign bus.avs_readdata = readdata_q;
  assign led_out          = led_q;

endmodule
